// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the memory fill / write-through sequencer.
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of the word-within-line index; kept at least 1 bit wide.
  function automatic int offs_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mem_beat_ctr.sv
// Beat counter for line fills: loads a start beat, steps on each accepted beat,
// wraps modulo the line length and flags the final beat of the line.
module mem_beat_ctr
  import mem_fill_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  localparam int OFFS_W = offs_w(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [OFFS_W-1:0] load_val,
  input  logic              inc,
  output logic [OFFS_W-1:0] beat,
  output logic              last_beat
);

  logic [OFFS_W-1:0] start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat    <= '0;
      start_q <= '0;
    end else if (load) begin
      beat    <= load_val;
      start_q <= load_val;
    end else if (inc) begin
      beat <= beat + OFFS_W'(1);
    end
  end

  // The line is complete once the beat just before the starting one is reached.
  assign last_beat = (beat == (start_q - OFFS_W'(1)));

endmodule

// File: rtl/mem_fill_engine.sv
// Memory-side sequencer: multi-beat line fills and single-word write-through.
// Optional: define MEM_FILL_CRITICAL_WORD_FIRST_EN to start fills at the requested word.
module mem_fill_engine
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFFS_W = offs_w(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_ctr,
  input  logic              m_strobe,
  input  logic              m_rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ctr_sig,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              fill_we,
  output logic [OFFS_W-1:0] fill_idx,
  output logic [DATA_W-1:0] fill_data
);

  state_t                   state;
  logic [ADDR_W-OFFS_W-1:0] line_tag;
  logic [OFFS_W-1:0]        beat;
  logic [OFFS_W-1:0]        next_beat;
  logic [OFFS_W-1:0]        first_beat;
  logic                     last_beat;
  logic                     start;

  assign start     = ld_ctr & m_strobe;
  assign next_beat = beat + OFFS_W'(1);

`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
  assign first_beat = addr[OFFS_W-1:0];
`else
  assign first_beat = '0;
`endif

  mem_beat_ctr #(.WORDS_PER_LINE(WORDS_PER_LINE)) u_beat_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      ((state == IDLE) && start),
    .load_val  (first_beat),
    .inc       ((state == RD_REQ) && mem_ack),
    .beat      (beat),
    .last_beat (last_beat)
  );

  // Handshake: mem_req is the valid and mem_ack the ready. A beat transfers on
  // any cycle where both are high; mem_req, mem_we, mem_addr and mem_wdata hold
  // unchanged until that cycle, however long memory stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      line_tag  <= '0;
      ctr_sig   <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fill_we   <= 1'b0;
      fill_idx  <= '0;
      fill_data <= '0;
    end else begin
      ctr_sig <= 1'b0;
      fill_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            line_tag <= addr[ADDR_W-1:OFFS_W];
            unique case (m_rw)
              RW_READ: begin
                state    <= RD_REQ;
                mem_we   <= 1'b0;
                mem_addr <= {addr[ADDR_W-1:OFFS_W], first_beat};
              end
              RW_WRITE: begin
                state     <= WR_REQ;
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= wdata;
              end
            endcase
          end
        end
        RD_REQ: begin
          if (mem_ack) begin
            fill_we   <= 1'b1;
            fill_idx  <= beat;
            fill_data <= mem_rdata;
            if (last_beat) begin
              state   <= DONE;
              mem_req <= 1'b0;
              ctr_sig <= 1'b1;
            end else begin
              mem_addr <= {line_tag, next_beat};
            end
          end
        end
        WR_REQ: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ctr_sig <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_fill_engine.md
Name: mem_fill_engine

Overview:
Memory-side sequencer directly downstream of the cache controller FSM. It consumes the controller's memory request (ld_ctr, m_strobe, m_rw) and performs one of two operations:
- a multi-beat line fill from main memory into the cache data array, or
- a single-word write-through to main memory.
It returns ctr_sig, the "memory operation complete" signal the controller waits on.

Parameters:
ADDR_W, 16, word-address width
DATA_W, 32, data word width
WORDS_PER_LINE, 4, beats per line fill; power of 2, >=2

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
ld_ctr  in  1  controller load pulse; starts an operation when qualified by m_strobe
m_strobe  in  1  controller memory strobe
m_rw  in  1  1 = read/line fill, 0 = write-through
addr  in  ADDR_W  CPU word address
wdata  in  DATA_W  write-through data
ctr_sig  out  1  one-cycle completion pulse to controller
busy  out  1  high while an operation is in progress
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable, valid with mem_req
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory accepts/returns one beat this cycle
fill_we  out  1  cache data-array write strobe
fill_idx  out  log2(WORDS_PER_LINE)  word index within line
fill_data  out  DATA_W  word to write into cache

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0: ctr_sig, busy, mem_req, mem_we, mem_addr, mem_wdata, fill_we, fill_idx, fill_data. Internal latches cleared.
- Reset mid-operation: mem_req drops immediately. The operation is abandoned and no ctr_sig is issued.
- States: IDLE, RD_REQ, WR_REQ, DONE.
- IDLE: start = ld_ctr & m_strobe. On start:
  - latch addr, wdata and m_rw.
  - line_base = addr with the low log2(WORDS_PER_LINE) bits cleared; beat = 0.
  - next state RD_REQ if m_rw=1, else WR_REQ.
  - ld_ctr or m_strobe alone is ignored.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_addr = line_base | beat.
  - On mem_ack: capture mem_rdata. Next cycle fill_we=1, fill_idx=beat, fill_data=captured word.
  - If beat is the last beat, go to DONE; else beat+1 and stay in RD_REQ.
  - Back-to-back acks are allowed: one beat per acked cycle. Stall is unbounded; mem_addr is held stable while unacked.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr = latched addr, mem_wdata = latched wdata.
  - On mem_ack, go to DONE. No fill_we is issued.
- DONE: ctr_sig=1 for exactly one cycle, then IDLE. For a fill, the last fill_we coincides with ctr_sig.
- busy=1 in every state except IDLE. start while busy is ignored, including during the DONE cycle.
- mem_ack while in IDLE or DONE is ignored.
- Latency, read with ack every cycle: start at cycle t → mem_req from t+1. Acks at t+1..t+WORDS_PER_LINE → ctr_sig at t+WORDS_PER_LINE+1.
- Latency, write: ack at cycle a → ctr_sig at a+1.
- The beat counter wraps modulo WORDS_PER_LINE. Address arithmetic never carries out of the line.

Optional Feature:
MEM_FILL_CRITICAL_WORD_FIRST_EN
- Defined: the first beat = word offset of the latched addr. Subsequent beats increment modulo WORDS_PER_LINE, wrapping through 0, for WORDS_PER_LINE beats total. fill_idx follows the actual beat. ctr_sig still follows the final beat.
- Undefined: beats always run 0..WORDS_PER_LINE-1.

Decomposition:
- Package mem_fill_pkg:
  - state enum type (IDLE, RD_REQ, WR_REQ, DONE)
  - OFFS_W = $clog2(WORDS_PER_LINE) helper
  - RW_READ / RW_WRITE constants
- Sub-module mem_beat_ctr:
  - load value (0 or critical offset), increment-on-ack, wrap modulo WORDS_PER_LINE
  - last_beat flag (beat == start-1 modulo, i.e. after WORDS_PER_LINE beats)

Test Plan:
- Reset, then read addr=0x0106, ack every cycle → mem_addr 0x0104,0x0105,0x0106,0x0107. fill_idx 0..3 on consecutive cycles with fill_data = returned data. ctr_sig single pulse on the cycle of fill_idx=3. busy low the next cycle.
- Same read with ack low 3 cycles before beat 2 → mem_addr holds 0x0106 and mem_req stays high for those 3 cycles. Completion is delayed by exactly 3 cycles.
- Write addr=0x0200, wdata=0xDEADBEEF, ack after 2 stall cycles → mem_we=1 with those values throughout. ctr_sig one cycle after ack. fill_we never asserts.
- Start pulses (ld_ctr & m_strobe) during an active fill and during DONE → ignored; exactly one ctr_sig. ld_ctr without m_strobe in IDLE → no request.
- reset_n low after beat 1 of a fill → mem_req/fill_we/busy drop immediately. After release, IDLE with no ctr_sig. A new read completes normally.
- With MEM_FILL_CRITICAL_WORD_FIRST_EN, read addr=0x0106 → mem_addr 0x0106,0x0107,0x0104,0x0105; fill_idx 2,3,0,1; ctr_sig with the fill_idx=1 write.
